uart_tx_frame: RTL

Transmit-side UART framer. It accepts one parallel data word through a valid/busy handshake and serialises it LSB-first on a single line: start bit, data bits, optional parity bit, stop bit(s). Each bit is held for Prescale CLK cycles, so it uses the same oversampled clock and Prescale setting as the receive path and produces frames that the receive path samples mid-bit.

---
 rtl/uart_tx_frame.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Transmit-side UART framer. It accepts one parallel word through a valid/busy
// handshake and serialises it LSB-first:
//   start bit (0), data bits, optional parity bit, stop bit(s) (1).
// Each bit is held for Prescale CLK cycles, using the same oversampled clock
// as the receive path. Prescale = 0 is treated as 1 cycle per bit.
//
// Configuration macro:
//   UART_TX_STOP2_EN  defined   -> two stop bits (2*Pc cycles of idle-high)
//                     undefined -> one stop bit
//
// Ports:
//   CLK         in   oversampled clock
//   RST         in   asynchronous, active-low reset
//   P_DATA      in   word to transmit (DATA_WIDTH bits)
//   Data_Valid  in   request; accepted only while Busy = 0
//   PAR_EN      in   1 = append parity bit
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   Prescale    in   CLK cycles per bit (PRESCALE_WIDTH bits)
//   TX_OUT      out  serial line, idle high, driven from a flop
//   Busy        out  frame in progress, driven from a flop
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int                IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state, state_nxt;
    logic [PRESCALE_WIDTH-1:0] cnt, cnt_nxt;
    logic [PRESCALE_WIDTH-1:0] pc_last, pc_last_nxt;   // captured Prescale minus one
    logic [IDX_W-1:0]          bit_idx, bit_idx_nxt;
    logic [DATA_WIDTH-1:0]     shadow, shadow_nxt;
    logic                      par_en, par_en_nxt;
    logic                      par_typ, par_typ_nxt;
    logic                      tx_nxt, busy_nxt;
    logic                      bit_done;
`ifdef UART_TX_STOP2_EN
    logic                      stop_second, stop_second_nxt;  // in second stop bit
`endif

    assign bit_done = (cnt == pc_last);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_last_nxt = pc_last;
        bit_idx_nxt = bit_idx;
        shadow_nxt  = shadow;
        par_en_nxt  = par_en;
        par_typ_nxt = par_typ;
`ifdef UART_TX_STOP2_EN
        stop_second_nxt = stop_second;
`endif
        tx_nxt      = 1'b1;
        busy_nxt    = 1'b0;

        // Bit timer free-runs 0..Pc-1 whenever a frame is in progress.
        if (state != IDLE) begin
            cnt_nxt = bit_done ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    state_nxt   = START;
                    shadow_nxt  = P_DATA;
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    // Prescale of 0 behaves as 1, so both map to a last count of 0.
                    pc_last_nxt = (Prescale == '0) ? '0 : Prescale - 1'b1;
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
`ifdef UART_TX_STOP2_EN
                    stop_second_nxt = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = par_en ? PARITY : STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
`ifdef UART_TX_STOP2_EN
                    if (!stop_second) begin
                        stop_second_nxt = 1'b1;
                    end else begin
                        stop_second_nxt = 1'b0;
                        state_nxt       = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // the line changes on the same edge as the state (zero latency).
        case (state_nxt)
            START: begin
                tx_nxt   = 1'b0;
                busy_nxt = 1'b1;
            end
            DATA: begin
                tx_nxt   = shadow_nxt[bit_idx_nxt];
                busy_nxt = 1'b1;
            end
            PARITY: begin
                tx_nxt   = (^shadow_nxt) ^ par_typ_nxt;
                busy_nxt = 1'b1;
            end
            STOP: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b1;
            end
            default: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            pc_last <= '0;
            bit_idx <= '0;
            // NOTE: the shadow word is a handful of flops, so it is reset with
            // everything else; it is reloaded on every acceptance anyway.
            shadow  <= '0;
            par_en  <= 1'b0;
            par_typ <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_second <= 1'b0;
`endif
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pc_last <= pc_last_nxt;
            bit_idx <= bit_idx_nxt;
            shadow  <= shadow_nxt;
            par_en  <= par_en_nxt;
            par_typ <= par_typ_nxt;
`ifdef UART_TX_STOP2_EN
            stop_second <= stop_second_nxt;
`endif
            TX_OUT  <= tx_nxt;
            Busy    <= busy_nxt;
        end
    end

endmodule
